uart_tx_arbiter: RTL and testbench

- Shares one 8N1 UART transmitter and its external baud-rate generator between NREQ byte requesters, using round-robin arbitration.
- Per frame, it loads the generator's divisor from a rate select and holds the generator in reset while idle, so every start bit is a full period.
- It serialises the granted byte on tx using the generator's tick.
- It sits between on-chip byte producers (debug console, status reporter) and the board UART pin.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_rr_arbiter.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors for a 50 MHz clock, the rate_sel
// encoding, and the transmitter state enum.
package uart_pkg;

  localparam logic [15:0] BAUD_DIV_9600   = 16'd5207;
  localparam logic [15:0] BAUD_DIV_38400  = 16'd1301;
  localparam logic [15:0] BAUD_DIV_57600  = 16'd867;
  localparam logic [15:0] BAUD_DIV_115200 = 16'd433;

  typedef enum logic [1:0] {
    RATE_9600   = 2'd0,
    RATE_38400  = 2'd1,
    RATE_57600  = 2'd2,
    RATE_115200 = 2'd3
  } rate_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [15:0] baud_div(input logic [1:0] sel);
    case (sel)
      RATE_9600:   baud_div = BAUD_DIV_9600;
      RATE_38400:  baud_div = BAUD_DIV_38400;
      RATE_57600:  baud_div = BAUD_DIV_57600;
      RATE_115200: baud_div = BAUD_DIV_115200;
      default:     baud_div = BAUD_DIV_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, baud-generator and serial-line signals of the shared UART
// transmitter. The slave modport is the arbiter's view.
interface uart_tx_arbiter_if #(parameter int NREQ = 2);

  logic [1:0]        rate_sel;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        grant_id;
  logic              busy;
  logic [15:0]       baud_value;
  logic              baud_en;
  logic              baud_tick;
  logic              tx;

  modport master (
    output rate_sel, req_valid, req_data, baud_tick,
    input  req_ready, grant_id, busy, baud_value, baud_en, tx
  );

  modport slave (
    input  rate_sel, req_valid, req_data, baud_tick,
    output req_ready, grant_id, busy, baud_value, baud_en, tx
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first pending requester searching upward
// from last_grant+1, wrapping modulo NREQ.
module uart_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_grant,
  output logic [2:0]      winner,
  output logic            valid
);

  // k runs from the lowest priority down so the nearest candidate is written last.
  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
          winner = 3'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared 8N1 UART transmitter. Latches the divisor at grant and
// keeps the external baud generator in reset whenever no frame is in flight.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  tx_state_t       state;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic [2:0]      last_grant;
  logic [2:0]      winner;
  logic            win_valid;
  logic [7:0]      sel_byte;
  logic [NREQ-1:0] ready_sel;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_comb begin
    sel_byte  = 8'h00;
    ready_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 3'(i)) begin
        sel_byte     = bus.req_data[8*i +: 8];
        ready_sel[i] = 1'b1;
      end
    end
  end

  // Every output is a register so the reset state reaches the pin without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shift          <= 8'h00;
      bit_cnt        <= 3'd0;
      last_grant     <= 3'(NREQ - 1);
      bus.grant_id   <= 3'd0;
      bus.req_ready  <= '0;
      bus.busy       <= 1'b0;
      bus.baud_value <= BAUD_DIV_9600;
      bus.baud_en    <= 1'b0;
      bus.tx         <= 1'b1;
    end else begin
      bus.req_ready <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            shift          <= sel_byte;
            last_grant     <= winner;
            bus.grant_id   <= winner;
            bus.req_ready  <= ready_sel;
            bus.baud_value <= baud_div(bus.rate_sel);
            bus.baud_en    <= 1'b1;
            bus.busy       <= 1'b1;
            bus.tx         <= 1'b0;
            state          <= START;
          end
        end
        START: begin
          if (bus.baud_tick) begin
            bus.tx  <= shift[0];
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bus.baud_tick) begin
            if (bit_cnt != 3'd7) begin
              bus.tx  <= shift[1];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              bus.tx <= 1'b1;
              state  <= STOP;
            end
          end
        end
        STOP: begin
          if (bus.baud_tick) begin
            bus.baud_en <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural baud generator
// (count held at 0 while disabled, tick when count equals the divisor).
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  uart_tx_arbiter_if #(.NREQ(2)) bus ();

  uart_tx_arbiter #(.NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] gen_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          gen_cnt <= 16'd0;
    else if (!bus.baud_en)              gen_cnt <= 16'd0;
    else if (gen_cnt == bus.baud_value) gen_cnt <= 16'd0;
    else                                gen_cnt <= gen_cnt + 16'd1;
  end
  assign bus.baud_tick = bus.baud_en && (gen_cnt == bus.baud_value);

  // Called at the negedge after a grant edge (frame cycle 0); records tx at the
  // first and last cycle of each of the 10 bits and returns at frame cycle 10*(b+1).
  task automatic sample_frame(input int b, output logic [9:0] first_s,
                              output logic [9:0] last_s, output int busy_fall,
                              output int ready_extra);
    int k;
    int off;
    first_s = '0;
    last_s = '0;
    busy_fall = -1;
    ready_extra = 0;
    for (int c = 0; c <= 10 * (b + 1); c++) begin
      if (c > 0) @(negedge clk);
      k = c / (b + 1);
      off = c % (b + 1);
      if (k < 10 && off == 0) first_s[k] = bus.tx;
      if (k < 10 && off == b) last_s[k] = bus.tx;
      if (busy_fall < 0 && bus.busy !== 1'b1) busy_fall = c;
      if (c > 0 && bus.req_ready !== 2'b00) ready_extra++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.baud_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_baud_en: got %b want 0", bus.baud_en); end
    checks++; if (bus.baud_value !== 16'd5207) begin errors++; $display("[TB] FAIL reset_baud_value: got %0d want 5207", bus.baud_value); end
    checks++; if (bus.grant_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.busy); end
  endtask

  // Both requesters always pending; ends with a reset during the fourth frame.
  task automatic test_contention_and_reset();
    logic [9:0] f_s, l_s, exp;
    int bf, rx, g;
    logic [7:0] byte_g;
    bus.rate_sel = 2'd3;
    bus.req_data = {8'h22, 8'h11};
    bus.req_valid = 2'b11;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01 || bus.grant_id !== 3'd0) begin errors++; $display("[TB] FAIL cont_grant0: ready=%b id=%0d want ready=01 id=0", bus.req_ready, bus.grant_id); end
    g = 0;
    for (int i = 0; i < 3; i++) begin
      byte_g = (g == 0) ? 8'h11 : 8'h22;
      exp = {1'b1, byte_g, 1'b0};
      sample_frame(433, f_s, l_s, bf, rx);
      checks++; if (f_s !== exp || l_s !== exp) begin errors++; $display("[TB] FAIL cont_frame%0d_bits: first=%b last=%b want %b", i, f_s, l_s, exp); end
      g = g ^ 1;
      @(negedge clk);
      checks++; if (bus.req_ready !== (2'b01 << g) || bus.grant_id !== 3'(g)) begin errors++; $display("[TB] FAIL cont_grant%0d: ready=%b id=%0d want id=%0d after 4341 cycles", i + 1, bus.req_ready, bus.grant_id, g); end
    end
    bus.req_valid = 2'b10;
    repeat (3 * 434 + 200) @(negedge clk);
    checks++; if (bus.tx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_bit2: got %b want 0", bus.tx); end
    reset = 1'b1;
    #1;
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_tx: got %b want 1", bus.tx); end
    checks++; if (bus.baud_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_en_busy: en=%b busy=%b want 0 0", bus.baud_en, bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL async_reset_ready: got %b want 00", bus.req_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b10 || bus.grant_id !== 3'd1) begin errors++; $display("[TB] FAIL regrant_after_reset: ready=%b id=%0d want 10 1", bus.req_ready, bus.grant_id); end
    bus.req_valid = 2'b00;
    exp = {1'b1, 8'h22, 1'b0};
    sample_frame(433, f_s, l_s, bf, rx);
    checks++; if (f_s !== exp || l_s !== exp) begin errors++; $display("[TB] FAIL resend_bits: first=%b last=%b want %b", f_s, l_s, exp); end
    checks++; if (bf !== 4340) begin errors++; $display("[TB] FAIL resend_busy_fall: got %0d want 4340", bf); end
  endtask

  task automatic test_single_byte();
    logic [9:0] f_s, l_s;
    int bf, rx;
    bus.rate_sel = 2'd3;
    bus.req_data = {8'h00, 8'hA5};
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b want 01", bus.req_ready); end
    checks++; if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.baud_en !== 1'b1) begin errors++; $display("[TB] FAIL single_grant_outs: tx=%b busy=%b en=%b want 0 1 1", bus.tx, bus.busy, bus.baud_en); end
    checks++; if (bus.baud_value !== 16'd433) begin errors++; $display("[TB] FAIL single_baud_value: got %0d want 433", bus.baud_value); end
    bus.req_valid = 2'b00;
    sample_frame(433, f_s, l_s, bf, rx);
    checks++; if (f_s !== 10'b1101001010) begin errors++; $display("[TB] FAIL single_bit_starts: got %b want 1101001010", f_s); end
    checks++; if (l_s !== 10'b1101001010) begin errors++; $display("[TB] FAIL single_bit_ends: got %b want 1101001010", l_s); end
    checks++; if (bf !== 4340) begin errors++; $display("[TB] FAIL single_busy_fall: got %0d want 4340", bf); end
    checks++; if (rx !== 0) begin errors++; $display("[TB] FAIL single_ready_extra: got %0d want 0", rx); end
    checks++; if (bus.baud_en !== 1'b0 || bus.tx !== 1'b1) begin errors++; $display("[TB] FAIL single_end_idle: en=%b tx=%b want 0 1", bus.baud_en, bus.tx); end
  endtask

  // Frame at 9600 with rate_sel switched mid-frame; requester 1 rises in the
  // last cycle of the stop bit.
  task automatic test_rate_latch_back_to_back();
    logic [9:0] f_s, l_s, exp;
    int bf, rx;
    logic [15:0] mid_value;
    bus.rate_sel = 2'd0;
    bus.req_data = {8'hC3, 8'h3C};
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01 || bus.baud_value !== 16'd5207) begin errors++; $display("[TB] FAIL latch_grant: ready=%b value=%0d want 01 5207", bus.req_ready, bus.baud_value); end
    bus.req_valid = 2'b00;
    mid_value = 16'd0;
    fork
      sample_frame(5207, f_s, l_s, bf, rx);
      begin
        repeat (1000) @(negedge clk);
        bus.rate_sel = 2'd3;
        repeat (1000) @(negedge clk);
        mid_value = bus.baud_value;
        repeat (50079) @(negedge clk);
        bus.req_valid = 2'b10;
      end
    join
    exp = {1'b1, 8'h3C, 1'b0};
    checks++; if (mid_value !== 16'd5207) begin errors++; $display("[TB] FAIL latch_mid_value: got %0d want 5207", mid_value); end
    checks++; if (f_s !== exp || l_s !== exp) begin errors++; $display("[TB] FAIL latch_bits: first=%b last=%b want %b", f_s, l_s, exp); end
    checks++; if (bf !== 52080) begin errors++; $display("[TB] FAIL latch_busy_fall: got %0d want 52080", bf); end
    checks++; if (bus.baud_en !== 1'b0 || bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL b2b_idle_cycle: en=%b ready=%b want 0 00", bus.baud_en, bus.req_ready); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b10 || bus.grant_id !== 3'd1 || bus.baud_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_grant: ready=%b id=%0d en=%b want 10 1 1", bus.req_ready, bus.grant_id, bus.baud_en); end
    checks++; if (bus.baud_value !== 16'd433) begin errors++; $display("[TB] FAIL b2b_new_rate: got %0d want 433", bus.baud_value); end
    bus.req_valid = 2'b00;
    exp = {1'b1, 8'hC3, 1'b0};
    sample_frame(433, f_s, l_s, bf, rx);
    checks++; if (f_s !== exp || l_s !== exp) begin errors++; $display("[TB] FAIL b2b_bits: first=%b last=%b want %b", f_s, l_s, exp); end
    checks++; if (bf !== 4340) begin errors++; $display("[TB] FAIL b2b_busy_fall: got %0d want 4340", bf); end
  endtask

  initial begin
    reset = 1'b1;
    bus.rate_sel = 2'd0;
    bus.req_valid = 2'b00;
    bus.req_data = 16'h0000;
    test_reset();
    test_contention_and_reset();
    test_single_byte();
    test_rate_latch_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
